// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch control codes, PC-unit states and reset PC.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_NOP  = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_JAL  = 3'b101,
    BR_JALR = 3'b110,
    BR_RSVD = 3'b111
  } br_cntrl_e;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IALIGN = 32: any target not on a word boundary traps.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC target selection and misalignment detection.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [2:0]  br_cntrl_i,
  input  logic        take_branch_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  logic [31:0] pc_plus4_s;
  logic [31:0] pc_rel_s;
  logic [31:0] jalr_sum_s;
  br_cntrl_e   br_s;

  assign pc_plus4_s = pc_i + 32'd4;
  assign pc_rel_s   = pc_i + imm_i;
  assign jalr_sum_s = rs1_i + imm_i;
  assign br_s       = br_cntrl_e'(br_cntrl_i);

  // Select the control-flow target; the reserved code behaves as a NOP.
  always_comb begin
    target_o = pc_plus4_s;
    case (br_s)
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE: begin
        if (take_branch_i) target_o = pc_rel_s;
        else               target_o = pc_plus4_s;
      end
      BR_JAL:  target_o = pc_rel_s;
      BR_JALR: target_o = {jalr_sum_s[31:1], 1'b0};
      default: target_o = pc_plus4_s;
    endcase
  end

  assign misaligned_o = is_misaligned(target_o);

endmodule

// File: rtl/pc_unit.sv
// Program counter and fetch sequencer: BOOT/FETCH/EXEC/HALT FSM, PC register,
// sticky misaligned-target trap and retired-instruction counter.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        take_branch,
  input  logic [2:0]  br_cntrl,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        exec_valid,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic [63:0] instret
);

  pc_state_e   state_q;
  logic [31:0] pc_q;
  logic        req_valid_q;
  logic        exec_valid_q;
  logic        trap_q;
  logic [31:0] trap_addr_q;
  logic [63:0] instret_q;

  logic [31:0] pc_d;
  logic [63:0] instret_d;
  logic        misaligned_s;

  pc_next_calc u_pc_next_calc (
    .pc_i          (pc_q),
    .br_cntrl_i    (br_cntrl),
    .take_branch_i (take_branch),
    .imm_i         (imm),
    .rs1_i         (rs1),
    .target_o      (pc_d),
    .misaligned_o  (misaligned_s)
  );

  assign instret_d = instret_q + 64'd1;

  // FSM with registered handshake/exec outputs; rst overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      exec_valid_q <= 1'b0;
      trap_q       <= 1'b0;
      trap_addr_q  <= 32'h0000_0000;
      instret_q    <= 64'd0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q     <= FETCH;
          req_valid_q <= 1'b1;
        end
        FETCH: begin
          if (req_valid_q && imem_req_ready) begin
            state_q      <= EXEC;
            req_valid_q  <= 1'b0;
            exec_valid_q <= 1'b1;
          end
        end
        EXEC: begin
          // A stalled cycle defers the trap decision as well as the update.
          if (!stall) begin
            exec_valid_q <= 1'b0;
            if (misaligned_s) begin
              state_q     <= HALT;
              trap_q      <= 1'b1;
              trap_addr_q <= pc_d;
            end else begin
              state_q     <= FETCH;
              req_valid_q <= 1'b1;
              pc_q        <= pc_d;
              instret_q   <= instret_d;
            end
          end
        end
        HALT: begin
          req_valid_q  <= 1'b0;
          exec_valid_q <= 1'b0;
        end
        default: begin
          state_q      <= BOOT;
          req_valid_q  <= 1'b0;
          exec_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign exec_valid     = exec_valid_q;
  assign trap           = trap_q;
  assign trap_addr      = trap_addr_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: fetch addresses go through a scoreboard
// queue, per-scenario tasks check PC, trap and counter behaviour.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        take_branch;
  logic [2:0]  br_cntrl;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_valid;
  logic        trap;
  logic [31:0] trap_addr;
  logic [63:0] instret;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_fetch_cyc = 0;
  int          fetch_gap = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;
  logic [63:0] exp_instret;

  pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .take_branch    (take_branch),
    .br_cntrl       (br_cntrl),
    .imm            (imm),
    .rs1            (rs1),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .exec_valid     (exec_valid),
    .trap           (trap),
    .trap_addr      (trap_addr),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_target(input logic [31:0] cur, input logic [2:0] br,
                                               input logic tkb, input logic [31:0] iv,
                                               input logic [31:0] rv);
    logic [31:0] t;
    case (br)
      3'd1, 3'd2, 3'd3, 3'd4: t = tkb ? cur + iv : cur + 32'd4;
      3'd5:    t = cur + iv;
      3'd6:    t = (rv + iv) & 32'hFFFF_FFFE;
      default: t = cur + 32'd4;
    endcase
    return t;
  endfunction

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, exec_valid, trap} !== 3'b000) begin
      failures++;
      $display("FAIL %s_flags: valid/exec/trap=%b required 000", tag, {imem_req_valid, exec_valid, trap});
    end
    checks++;
    if (pc !== 32'h0 || trap_addr !== 32'h0 || instret !== 64'd0) begin
      failures++;
      $display("FAIL %s_regs: pc=%h trap_addr=%h instret=%0d required 0/0/0", tag, pc, trap_addr, instret);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL %s_first_req: valid=%b addr=%h required 1/00000000", tag, imem_req_valid, imem_addr);
    end
    sb.delete();
    sb.push_back(32'h0);
    exp_pc = 32'h0;
    exp_instret = 64'd0;
  endtask

  task automatic do_instr(input logic [2:0] br, input logic tkb, input logic [31:0] iv,
                          input logic [31:0] rv, input int nstall);
    int n = 0;
    logic [31:0] want;
    logic [31:0] tgt;
    imem_req_ready = 1'b1;
    while (imem_req_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 10) begin
      failures++;
      $display("FAIL fetch_timeout: valid=%b after %0d cycles required 1", imem_req_valid, n);
      return;
    end
    if (sb.size() == 0) begin
      want = 32'hDEAD_BEEF;
    end else begin
      want = sb.pop_front();
    end
    checks++;
    if (imem_addr !== want || pc !== want) begin
      failures++;
      $display("FAIL fetch_addr: addr=%h pc=%h required %h", imem_addr, pc, want);
    end
    fetch_gap = cyc - last_fetch_cyc;
    last_fetch_cyc = cyc;
    br_cntrl = br;
    take_branch = tkb;
    imm = iv;
    rs1 = rv;
    stall = (nstall > 0);
    tgt = model_target(exp_pc, br, tkb, iv, rv);
    checks++;
    if (pc_plus4 !== exp_pc + 32'd4) begin
      failures++;
      $display("FAIL pc_plus4: got %h required %h", pc_plus4, exp_pc + 32'd4);
    end
    @(negedge clk);
    checks++;
    if ({exec_valid, imem_req_valid} !== 2'b10) begin
      failures++;
      $display("FAIL exec_entry: exec/valid=%b required 10", {exec_valid, imem_req_valid});
    end
    for (int i = 0; i < nstall; i++) begin
      @(negedge clk);
      checks++;
      if (exec_valid !== 1'b1 || pc !== exp_pc || instret !== exp_instret) begin
        failures++;
        $display("FAIL stall_hold: exec=%b pc=%h instret=%0d required 1/%h/%0d",
                 exec_valid, pc, instret, exp_pc, exp_instret);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    if (tgt[1:0] != 2'b00) begin
      checks++;
      if (trap !== 1'b1 || trap_addr !== tgt) begin
        failures++;
        $display("FAIL trap_raise: trap=%b trap_addr=%h required 1/%h", trap, trap_addr, tgt);
      end
      checks++;
      if (pc !== exp_pc || instret !== exp_instret || {imem_req_valid, exec_valid} !== 2'b00) begin
        failures++;
        $display("FAIL trap_hold: pc=%h instret=%0d valid/exec=%b required %h/%0d/00",
                 pc, instret, {imem_req_valid, exec_valid}, exp_pc, exp_instret);
      end
    end else begin
      exp_pc = tgt;
      exp_instret = exp_instret + 64'd1;
      sb.push_back(tgt);
      checks++;
      if (pc !== exp_pc || instret !== exp_instret) begin
        failures++;
        $display("FAIL pc_update: pc=%h instret=%0d required %h/%0d", pc, instret, exp_pc, exp_instret);
      end
      checks++;
      if ({imem_req_valid, exec_valid, trap} !== 3'b100) begin
        failures++;
        $display("FAIL refetch: valid/exec/trap=%b required 100", {imem_req_valid, exec_valid, trap});
      end
    end
    br_cntrl = 3'b000;
    take_branch = 1'b0;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_nops();
    for (int k = 0; k < 4; k++) begin
      do_instr(3'b000, 1'b0, 32'h0, 32'h0, 0);
      if (k > 0) begin
        checks++;
        if (fetch_gap !== 2) begin
          failures++;
          $display("FAIL nop_period: gap=%0d cycles required 2", fetch_gap);
        end
      end
    end
    checks++;
    if (instret !== 64'd4) begin
      failures++;
      $display("FAIL nop_instret: got %0d required 4", instret);
    end
  endtask

  task automatic test_branches();
    do_instr(3'b101, 1'b0, 32'h100 - exp_pc, 32'h0, 0);
    do_instr(3'b001, 1'b1, 32'h40, 32'h0, 0);
    do_instr(3'b101, 1'b1, 32'h100 - exp_pc, 32'h0, 0);
    do_instr(3'b001, 1'b0, 32'h40, 32'h0, 0);
    do_instr(3'b100, 1'b1, 32'hFFFF_FFF0, 32'h0, 0);
    do_instr(3'b111, 1'b1, 32'h80, 32'h0, 0);
    do_instr(3'b010, 1'b0, 32'h80, 32'h0, 0);
  endtask

  task automatic test_jalr();
    do_instr(3'b101, 1'b0, 32'h20 - exp_pc, 32'h0, 0);
    do_instr(3'b110, 1'b0, 32'h3, 32'h1002, 0);
    do_instr(3'b011, 1'b1, 32'hFFFF_FFFC, 32'h0, 0);
  endtask

  task automatic test_backpressure_stall();
    logic [31:0] held;
    imem_req_ready = 1'b0;
    held = imem_addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== held || exec_valid !== 1'b0) begin
        failures++;
        $display("FAIL backpressure: valid=%b addr=%h exec=%b required 1/%h/0",
                 imem_req_valid, imem_addr, exec_valid, held);
      end
    end
    do_instr(3'b000, 1'b0, 32'h0, 32'h0, 2);
    do_instr(3'b001, 1'b1, 32'h8, 32'h0, 1);
  endtask

  task automatic test_wrap();
    do_instr(3'b101, 1'b0, 32'hFFFF_FFFC - exp_pc, 32'h0, 0);
    do_instr(3'b000, 1'b0, 32'h0, 32'h0, 0);
    checks++;
    if (pc !== 32'h0 || trap !== 1'b0) begin
      failures++;
      $display("FAIL wrap: pc=%h trap=%b required 00000000/0", pc, trap);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_instr(3'b000, 1'b0, 32'h0, 32'h0, 0);
    imem_req_ready = 1'b1;
    do_reset("rst_fetch");
  endtask

  task automatic test_trap_halt();
    do_instr(3'b101, 1'b0, 32'h10, 32'h0, 0);
    do_instr(3'b101, 1'b0, 32'h6, 32'h0, 2);
    imem_req_ready = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({imem_req_valid, exec_valid, trap} !== 3'b001 || pc !== 32'h10 || trap_addr !== 32'h16) begin
        failures++;
        $display("FAIL halt_absorb: valid/exec/trap=%b pc=%h trap_addr=%h required 001/00000010/00000016",
                 {imem_req_valid, exec_valid, trap}, pc, trap_addr);
      end
    end
    stall = 1'b0;
    do_reset("rst_halt");
    do_instr(3'b000, 1'b0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    rst = 1'b1;
    take_branch = 1'b0;
    br_cntrl = 3'b000;
    imm = 32'h0;
    rs1 = 32'h0;
    stall = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_nops();
    test_branches();
    test_jalr();
    do_reset("reset2");
    test_backpressure_stall();
    test_wrap();
    test_reset_mid_fetch();
    test_trap_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
